gtx_lane_reset_mc: RTL and testbench
====================================

Name: gtx_lane_reset_mc

Overview:
Multi-lane GTX receive-health monitor and reset sequencer. It watches per-lane disparity-error and loss-of-sync flags over a fixed error window. When a lane's error count reaches threshold, that lane alone gets a timed reset pulse, followed by a settle hold-off. Repeated failures are bounded by a retry limit, after which the lane is parked in FAIL. It sits between the GTX wrapper and link logic and replaces single-lane, two-clock reset handling.

Parameters:
LANES, 4, number of GTX lanes monitored (1..16)
WIN_CYC, 156250, error-window length in clk cycles (1 ms at 156.25 MHz)
ERR_TH, 30, errored cycles within one window that trigger a lane reset (>=1, < WIN_CYC)
RST_CYC, 156, gtx_rst_out pulse width in clk cycles (>=1)
HOLDOFF_CYC, 1562500, settle time after reset before monitoring resumes (>=1)
MAX_RETRY, 3, threshold-triggered resets allowed without an intervening clean window

Ports:
clk  in  1  system clock; all inputs are synchronous to it
rst_in  in  1  asynchronous, active-high reset
rxdisperr  in  LANES  per-lane disparity-error flag
rxlossofsync  in  LANES  per-lane loss-of-sync flag
force_rst  in  LANES  per-lane manual reset request, level
clear_fail  in  1  single-cycle pulse; releases every lane in FAIL
gtx_rst_out  out  LANES  per-lane GTX reset, active high
lane_up  out  LANES  lane in MONITOR and has completed one clean window
lane_fail  out  LANES  lane parked in FAIL
rst_debug  out  4*LANES  per lane {state[1:0], retry_hit, err_now}

Behaviour:
- One window counter shared by all lanes: win_cnt runs 0..WIN_CYC-1 and wraps. win_end = (win_cnt == WIN_CYC-1).
- Per-lane state machine with states RESET, HOLDOFF, MONITOR, FAIL. Each lane has a timer, err_cnt (saturating at ERR_TH), retry_cnt (0..MAX_RETRY) and clean_seen.
- Reset (rst_in=1), asynchronous:
  - every lane enters RESET with timer=0, err_cnt=0, retry_cnt=0, clean_seen=0; win_cnt=0.
  - gtx_rst_out = all ones; lane_up = 0; lane_fail = 0.
- err_now = rxdisperr | rxlossofsync for that lane.
- RESET:
  - gtx_rst_out=1; timer counts.
  - At timer==RST_CYC-1, go to HOLDOFF with timer=0. The pulse is exactly RST_CYC cycles.
  - force_rst while in RESET restarts the timer at 0.
- HOLDOFF:
  - gtx_rst_out=0; errors ignored; err_cnt held at 0.
  - At timer==HOLDOFF_CYC-1, go to MONITOR with clean_seen=0.
  - force_rst goes to RESET next cycle.
- MONITOR:
  - Each cycle, err_cnt_next = err_cnt + err_now.
  - If err_cnt_next >= ERR_TH:
    - if retry_cnt == MAX_RETRY, go to FAIL;
    - else go to RESET with retry_cnt+1.
    - The transition happens on the clock edge that samples the ERR_TH-th error; gtx_rst_out rises one cycle after that error is presented.
  - Otherwise, on win_end, err_cnt loads 0. The error present on the win_end cycle counts toward the closing window, not the next one.
  - A full window that closes with err_cnt_next==0 and no threshold hit clears retry_cnt and sets clean_seen.
    - A partial first window after entering MONITOR does count as clean if it is error-free.
  - lane_up = clean_seen.
  - force_rst goes to RESET without incrementing retry_cnt.
  - Precedence when events coincide: threshold > force_rst > win_end bookkeeping.
- FAIL:
  - gtx_rst_out=1 (lane parked in reset); lane_fail=1; force_rst ignored.
  - clear_fail goes to RESET with retry_cnt=0 and timer=0.
- Lanes are fully independent. Simultaneous triggers on several lanes are all served in the same cycle; there is no arbitration.
- All counters are sized with $clog2 of their terminal value; no counter wraps except win_cnt.

Optional Feature:
Macro GTX_LANE_RST_STATS_EN.
- Defined:
  - adds output rst_count, width 16*LANES: a per-lane saturating count of RESET entries (threshold-triggered and forced; rst_in entry excluded).
  - adds output fail_count, width 8*LANES: a per-lane saturating count of FAIL entries.
  - Both are cleared only by rst_in.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Shared package gtx_rst_pkg holds:
  - the lane state enum (RESET=2'd0, HOLDOFF=2'd1, MONITOR=2'd2, FAIL=2'd3);
  - the debug-field bit offsets;
  - default constants for 156.25 MHz timing.
- One natural sub-module, gtx_lane_rst_fsm: per-lane state machine, timer, error counter and retry counter. It takes win_end as an input.
- The top holds the shared window counter and a generate loop of LANES instances.

Test Plan:
Use WIN_CYC=100, ERR_TH=5, RST_CYC=4, HOLDOFF_CYC=10, MAX_RETRY=2, LANES=4.
- Power-up: release rst_in, no errors -> gtx_rst_out=4'hF for 4 cycles, then 0; MONITOR after 10 more cycles; lane_up=1 at the first win_end.
- Lane 1: rxdisperr high for 5 cycles inside one window -> gtx_rst_out[1] rises one cycle after the 5th error and stays high exactly 4 cycles; lanes 0, 2, 3 unaffected; lane_up[1]=0 until a clean window.
- Lane 2: 4 errors before win_end plus 1 error on the win_end cycle -> reset triggered. Repeat with 4 errors before win_end and 1 just after -> no reset.
- Lane 0: three threshold triggers with no clean window between -> two RESET cycles, then lane_fail[0]=1 with gtx_rst_out[0] held at 1. clear_fail pulse -> 4-cycle reset sequence, retry_cnt=0.
- Lanes 0 and 3 cross threshold on the same cycle, with force_rst[3] also high -> both reset together; retry_cnt[3] increments (threshold wins).
- rst_in asserted mid-HOLDOFF -> all outputs return to reset values asynchronously. With GTX_LANE_RST_STATS_EN defined, rst_count equals the number of RESET entries and reads 0 after rst_in.

Source files
------------

// File: rtl/gtx_rst_pkg.sv
// Shared types and constants for the GTX lane reset sequencer.
// Optional statistics counters are enabled by defining GTX_LANE_RST_STATS_EN.
package gtx_rst_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_MONITOR = 2'd2,
    ST_FAIL    = 2'd3
  } lane_state_e;

  // Per-lane debug nibble layout: {state[1:0], retry_hit, err_now}
  localparam int DBG_W         = 4;
  localparam int DBG_ERR_NOW   = 0;
  localparam int DBG_RETRY_HIT = 1;
  localparam int DBG_STATE_LSB = 2;

  localparam int RST_CNT_W  = 16;
  localparam int FAIL_CNT_W = 8;

  // Defaults for a 156.25 MHz reference clock.
  localparam int DEF_LANES       = 4;
  localparam int DEF_WIN_CYC     = 156250;
  localparam int DEF_ERR_TH      = 30;
  localparam int DEF_RST_CYC     = 156;
  localparam int DEF_HOLDOFF_CYC = 1562500;
  localparam int DEF_MAX_RETRY   = 3;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gtx_lane_rst_fsm.sv
// Per-lane health state machine: reset pulse, settle hold-off, error window
// monitoring and retry bookkeeping. Stats under GTX_LANE_RST_STATS_EN.
module gtx_lane_rst_fsm
  import gtx_rst_pkg::*;
#(
  parameter int ERR_TH      = DEF_ERR_TH,
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxdisperr_i,
  input  logic                  rxlossofsync_i,
  input  logic                  force_rst_i,
  input  logic                  clear_fail_i,
  input  logic                  win_end_i,
  output logic                  gtx_rst_o,
  output logic                  lane_up_o,
  output logic                  lane_fail_o,
`ifdef GTX_LANE_RST_STATS_EN
  output logic [RST_CNT_W-1:0]  rst_count_o,
  output logic [FAIL_CNT_W-1:0] fail_count_o,
`endif
  output logic [DBG_W-1:0]      debug_o
);

  localparam int TMR_MAX = ((RST_CYC > HOLDOFF_CYC) ? RST_CYC : HOLDOFF_CYC) - 1;
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam int ERR_W   = cnt_w(ERR_TH);
  localparam int RTY_W   = cnt_w(MAX_RETRY);

  lane_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             clean_q, clean_d;

  logic             err_now;
  logic [ERR_W-1:0] err_next;
  logic             retry_hit;
  logic             enter_rst;
  logic             enter_fail;

  assign err_now   = rxdisperr_i | rxlossofsync_i;
  assign err_next  = (err_cnt_q == ERR_W'(ERR_TH)) ? err_cnt_q
                                                   : err_cnt_q + ERR_W'(err_now);
  assign retry_hit = (retry_q == RTY_W'(MAX_RETRY));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    err_cnt_d  = err_cnt_q;
    retry_d    = retry_q;
    clean_d    = clean_q;
    enter_rst  = 1'b0;
    enter_fail = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        err_cnt_d = '0;
        clean_d   = 1'b0;
        if (force_rst_i) begin
          timer_d = '0;
        end else if (timer_q == TMR_W'(RST_CYC - 1)) begin
          state_d = ST_HOLDOFF;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_HOLDOFF: begin
        err_cnt_d = '0;
        if (force_rst_i) begin
          state_d   = ST_RESET;
          timer_d   = '0;
          enter_rst = 1'b1;
        end else if (timer_q == TMR_W'(HOLDOFF_CYC - 1)) begin
          state_d = ST_MONITOR;
          timer_d = '0;
          clean_d = 1'b0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_MONITOR: begin
        // Threshold outranks a manual request, which outranks window bookkeeping.
        if (err_next >= ERR_W'(ERR_TH)) begin
          timer_d   = '0;
          err_cnt_d = '0;
          clean_d   = 1'b0;
          if (retry_hit) begin
            state_d    = ST_FAIL;
            enter_fail = 1'b1;
          end else begin
            state_d   = ST_RESET;
            retry_d   = retry_q + RTY_W'(1);
            enter_rst = 1'b1;
          end
        end else if (force_rst_i) begin
          state_d   = ST_RESET;
          timer_d   = '0;
          err_cnt_d = '0;
          clean_d   = 1'b0;
          enter_rst = 1'b1;
        end else if (win_end_i) begin
          err_cnt_d = '0;
          if (err_next == '0) begin
            retry_d = '0;
            clean_d = 1'b1;
          end
        end else begin
          err_cnt_d = err_next;
        end
      end

      ST_FAIL: begin
        if (clear_fail_i) begin
          state_d   = ST_RESET;
          timer_d   = '0;
          retry_d   = '0;
          enter_rst = 1'b1;
        end
      end

      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_RESET;
      timer_q   <= '0;
      err_cnt_q <= '0;
      retry_q   <= '0;
      clean_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
      retry_q   <= retry_d;
      clean_q   <= clean_d;
    end
  end

  assign gtx_rst_o   = (state_q == ST_RESET) || (state_q == ST_FAIL);
  assign lane_up_o   = (state_q == ST_MONITOR) && clean_q;
  assign lane_fail_o = (state_q == ST_FAIL);

  always_comb begin
    debug_o                                = '0;
    debug_o[DBG_ERR_NOW]                   = err_now;
    debug_o[DBG_RETRY_HIT]                 = retry_hit;
    debug_o[DBG_STATE_LSB +: 2]            = state_q;
  end

`ifdef GTX_LANE_RST_STATS_EN
  logic [RST_CNT_W-1:0]  rst_cnt_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      if (enter_rst && (rst_cnt_q != '1))
        rst_cnt_q <= rst_cnt_q + RST_CNT_W'(1);
      if (enter_fail && (fail_cnt_q != '1))
        fail_cnt_q <= fail_cnt_q + FAIL_CNT_W'(1);
    end
  end

  assign rst_count_o  = rst_cnt_q;
  assign fail_count_o = fail_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = enter_rst ^ enter_fail;
`endif

endmodule

// File: rtl/gtx_lane_reset_mc.sv
// Multi-lane GTX receive-health monitor: shared error window plus one reset
// sequencer per lane. Statistics ports exist only with GTX_LANE_RST_STATS_EN.
module gtx_lane_reset_mc
  import gtx_rst_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int WIN_CYC     = DEF_WIN_CYC,
  parameter int ERR_TH      = DEF_ERR_TH,
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic [LANES-1:0]            rxdisperr,
  input  logic [LANES-1:0]            rxlossofsync,
  input  logic [LANES-1:0]            force_rst,
  input  logic                        clear_fail,
  output logic [LANES-1:0]            gtx_rst_out,
  output logic [LANES-1:0]            lane_up,
  output logic [LANES-1:0]            lane_fail,
`ifdef GTX_LANE_RST_STATS_EN
  output logic [RST_CNT_W*LANES-1:0]  rst_count,
  output logic [FAIL_CNT_W*LANES-1:0] fail_count,
`endif
  output logic [DBG_W*LANES-1:0]      rst_debug
);

  localparam int WIN_W = cnt_w(WIN_CYC - 1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             win_end;

  assign win_end = (win_cnt_q == WIN_W'(WIN_CYC - 1));

  always_comb begin
    win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) win_cnt_q <= '0;
    else        win_cnt_q <= win_cnt_d;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gtx_lane_rst_fsm #(
      .ERR_TH      (ERR_TH),
      .RST_CYC     (RST_CYC),
      .HOLDOFF_CYC (HOLDOFF_CYC),
      .MAX_RETRY   (MAX_RETRY)
    ) u_fsm (
      .clk            (clk),
      .rst            (rst_in),
      .rxdisperr_i    (rxdisperr[i]),
      .rxlossofsync_i (rxlossofsync[i]),
      .force_rst_i    (force_rst[i]),
      .clear_fail_i   (clear_fail),
      .win_end_i      (win_end),
      .gtx_rst_o      (gtx_rst_out[i]),
      .lane_up_o      (lane_up[i]),
      .lane_fail_o    (lane_fail[i]),
`ifdef GTX_LANE_RST_STATS_EN
      .rst_count_o    (rst_count[RST_CNT_W*i +: RST_CNT_W]),
      .fail_count_o   (fail_count[FAIL_CNT_W*i +: FAIL_CNT_W]),
`endif
      .debug_o        (rst_debug[DBG_W*i +: DBG_W])
    );
  end

endmodule

// File: tb/tb_gtx_lane_reset_mc.sv
// Directed bench for gtx_lane_reset_mc with small timing constants; each
// vector holds inputs for N cycles, then compares all lane outputs.
module tb_gtx_lane_reset_mc;

  localparam int LANES = 4;

  logic             clk = 1'b0;
  logic             rst_in = 1'b1;
  logic [LANES-1:0] rxdisperr = '0;
  logic [LANES-1:0] rxlossofsync = '0;
  logic [LANES-1:0] force_rst = '0;
  logic             clear_fail = 1'b0;
  logic [LANES-1:0] gtx_rst_out;
  logic [LANES-1:0] lane_up;
  logic [LANES-1:0] lane_fail;
  logic [4*LANES-1:0] rst_debug;
`ifdef GTX_LANE_RST_STATS_EN
  logic [16*LANES-1:0] rst_count;
  logic [8*LANES-1:0]  fail_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gtx_lane_reset_mc #(
    .LANES       (LANES),
    .WIN_CYC     (100),
    .ERR_TH      (5),
    .RST_CYC     (4),
    .HOLDOFF_CYC (10),
    .MAX_RETRY   (2)
  ) dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .rxdisperr    (rxdisperr),
    .rxlossofsync (rxlossofsync),
    .force_rst    (force_rst),
    .clear_fail   (clear_fail),
    .gtx_rst_out  (gtx_rst_out),
    .lane_up      (lane_up),
    .lane_fail    (lane_fail),
`ifdef GTX_LANE_RST_STATS_EN
    .rst_count    (rst_count),
    .fail_count   (fail_count),
`endif
    .rst_debug    (rst_debug)
  );

  typedef struct {
    logic [3:0]  disp;
    logic [3:0]  los;
    logic [3:0]  frc;
    logic        clr;
    int          n;
    logic [3:0]  e_rst;
    logic [3:0]  e_up;
    logic [3:0]  e_fail;
    logic [15:0] e_dbg;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] disp, input logic [3:0] los, input logic [3:0] frc,
                     input logic clr, input int n, input logic [3:0] e_rst,
                     input logic [3:0] e_up, input logic [3:0] e_fail, input logic [15:0] e_dbg);
    vec_t v;
    v.disp = disp; v.los = los; v.frc = frc; v.clr = clr; v.n = n;
    v.e_rst = e_rst; v.e_up = e_up; v.e_fail = e_fail; v.e_dbg = e_dbg;
    tbl.push_back(v);
  endtask

  initial begin
    // Comment on each row: edge count since reset release after the row.
    add(4'h0, 4'h0, 4'h0, 0,  3, 4'hF, 4'h0, 4'h0, 16'h0000); // 3   power-up pulse
    add(4'h0, 4'h0, 4'h0, 0,  1, 4'h0, 4'h0, 4'h0, 16'h4444); // 4   holdoff
    add(4'h0, 4'h0, 4'h0, 0, 10, 4'h0, 4'h0, 4'h0, 16'h8888); // 14  monitor
    add(4'h0, 4'h0, 4'h0, 0, 85, 4'h0, 4'h0, 4'h0, 16'h8888); // 99
    add(4'h0, 4'h0, 4'h0, 0,  1, 4'h0, 4'hF, 4'h0, 16'h8888); // 100 first win_end
    add(4'h2, 4'h0, 4'h0, 0,  4, 4'h0, 4'hF, 4'h0, 16'h8898); // 104 lane1 4 errors
    add(4'h2, 4'h0, 4'h0, 0,  1, 4'h2, 4'hD, 4'h0, 16'h8818); // 105 5th -> reset
    add(4'h0, 4'h0, 4'h0, 0,  3, 4'h2, 4'hD, 4'h0, 16'h8808); // 108
    add(4'h0, 4'h0, 4'h0, 0,  1, 4'h0, 4'hD, 4'h0, 16'h8848); // 109 pulse was 4
    add(4'h0, 4'h0, 4'h0, 0,  9, 4'h0, 4'hD, 4'h0, 16'h8848); // 118
    add(4'h0, 4'h0, 4'h0, 0,  1, 4'h0, 4'hD, 4'h0, 16'h8888); // 119
    add(4'h0, 4'h0, 4'h0, 0, 80, 4'h0, 4'hD, 4'h0, 16'h8888); // 199
    add(4'h0, 4'h0, 4'h0, 0,  1, 4'h0, 4'hF, 4'h0, 16'h8888); // 200 lane1 up
    add(4'h0, 4'h0, 4'h0, 0, 90, 4'h0, 4'hF, 4'h0, 16'h8888); // 290
    add(4'h4, 4'h0, 4'h0, 0,  4, 4'h0, 4'hF, 4'h0, 16'h8988); // 294 lane2 4 errors
    add(4'h0, 4'h0, 4'h0, 0,  5, 4'h0, 4'hF, 4'h0, 16'h8888); // 299
    add(4'h0, 4'h4, 4'h0, 0,  1, 4'h4, 4'hB, 4'h0, 16'h8188); // 300 error on win_end
    add(4'h0, 4'h0, 4'h0, 0,  4, 4'h0, 4'hB, 4'h0, 16'h8488); // 304
    add(4'h0, 4'h0, 4'h0, 0, 10, 4'h0, 4'hB, 4'h0, 16'h8888); // 314
    add(4'h0, 4'h0, 4'h0, 0, 81, 4'h0, 4'hB, 4'h0, 16'h8888); // 395
    add(4'h4, 4'h0, 4'h0, 0,  4, 4'h0, 4'hB, 4'h0, 16'h8988); // 399
    add(4'h0, 4'h0, 4'h0, 0,  1, 4'h0, 4'hB, 4'h0, 16'h8888); // 400 win_end
    add(4'h4, 4'h0, 4'h0, 0,  1, 4'h0, 4'hB, 4'h0, 16'h8988); // 401 no reset
    add(4'h1, 4'h0, 4'h0, 0,  5, 4'h1, 4'hA, 4'h0, 16'h8881); // 406 lane0 trig 1
    add(4'h0, 4'h0, 4'h0, 0, 14, 4'h0, 4'hA, 4'h0, 16'h8888); // 420
    add(4'h1, 4'h0, 4'h0, 0,  5, 4'h1, 4'hA, 4'h0, 16'h8883); // 425 trig 2
    add(4'h0, 4'h0, 4'h0, 0, 14, 4'h0, 4'hA, 4'h0, 16'h888A); // 439
    add(4'h1, 4'h0, 4'h0, 0,  5, 4'h1, 4'hA, 4'h1, 16'h888F); // 444 trig 3 -> fail
    add(4'h0, 4'h0, 4'h1, 0, 20, 4'h1, 4'hA, 4'h1, 16'h888E); // 464 force ignored
    add(4'h0, 4'h0, 4'h0, 1,  1, 4'h1, 4'hA, 4'h0, 16'h8880); // 465 clear_fail
    add(4'h0, 4'h0, 4'h0, 0,  3, 4'h1, 4'hA, 4'h0, 16'h8880); // 468
    add(4'h0, 4'h0, 4'h0, 0,  1, 4'h0, 4'hA, 4'h0, 16'h8884); // 469
    add(4'h0, 4'h0, 4'h0, 0, 10, 4'h0, 4'hA, 4'h0, 16'h8888); // 479
    add(4'h0, 4'h0, 4'h0, 0, 21, 4'h0, 4'hB, 4'h0, 16'h8888); // 500
    add(4'h8, 4'h0, 4'h0, 0,  5, 4'h8, 4'h3, 4'h0, 16'h1888); // 505 lane3 trig
    add(4'h0, 4'h0, 4'h0, 0, 14, 4'h0, 4'h3, 4'h0, 16'h8888); // 519
    add(4'h9, 4'h0, 4'h0, 0,  4, 4'h0, 4'h3, 4'h0, 16'h9889); // 523
    add(4'h9, 4'h0, 4'h8, 0,  1, 4'h9, 4'h2, 4'h0, 16'h3881); // 524 threshold beats force
    add(4'h0, 4'h0, 4'h0, 0, 14, 4'h0, 4'h2, 4'h0, 16'hA888); // 538
    add(4'h0, 4'h0, 4'h4, 0,  1, 4'h4, 4'h2, 4'h0, 16'hA088); // 539 forced, no retry
    add(4'h0, 4'h0, 4'h4, 0,  3, 4'h4, 4'h2, 4'h0, 16'hA088); // 542 timer restarts
    add(4'h0, 4'h0, 4'h0, 0,  3, 4'h4, 4'h2, 4'h0, 16'hA088); // 545
    add(4'h0, 4'h0, 4'h0, 0,  1, 4'h0, 4'h2, 4'h0, 16'hA488); // 546 lane2 holdoff

    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_gtx_rst", 64'(gtx_rst_out), 64'hF);
    check("rst_hold_lane_up", 64'(lane_up), 64'h0);
    check("rst_hold_lane_fail", 64'(lane_fail), 64'h0);
    check("rst_hold_debug", 64'(rst_debug), 64'h0);
    rst_in = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rxdisperr    = tbl[i].disp;
      rxlossofsync = tbl[i].los;
      force_rst    = tbl[i].frc;
      clear_fail   = tbl[i].clr;
      for (int c = 0; c < tbl[i].n; c++) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("v%0d_gtx_rst", i), 64'(gtx_rst_out), 64'(tbl[i].e_rst));
      check($sformatf("v%0d_lane_up", i), 64'(lane_up), 64'(tbl[i].e_up));
      check($sformatf("v%0d_lane_fail", i), 64'(lane_fail), 64'(tbl[i].e_fail));
      check($sformatf("v%0d_debug", i), 64'(rst_debug), 64'(tbl[i].e_dbg));
    end

    rxdisperr    = '0;
    rxlossofsync = '0;
    force_rst    = '0;
    clear_fail   = 1'b0;

`ifdef GTX_LANE_RST_STATS_EN
    check("stats_rst_count", 64'(rst_count), {16'd2, 16'd2, 16'd1, 16'd4});
    check("stats_fail_count", 64'(fail_count), 64'({8'd0, 8'd0, 8'd0, 8'd1}));
`endif

    // Asynchronous reset while lane 2 sits in HOLDOFF, between clock edges.
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_gtx_rst", 64'(gtx_rst_out), 64'hF);
    check("async_rst_lane_up", 64'(lane_up), 64'h0);
    check("async_rst_lane_fail", 64'(lane_fail), 64'h0);
    check("async_rst_debug", 64'(rst_debug), 64'h0);
`ifdef GTX_LANE_RST_STATS_EN
    check("async_rst_rst_count", 64'(rst_count), 64'h0);
    check("async_rst_fail_count", 64'(fail_count), 64'h0);
`endif

    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rerelease_gtx_rst", 64'(gtx_rst_out), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
